// File: rtl/fifo_uart_pkg.sv
// -----------------------------------------------------------------------------
// fifo_uart_pkg
// Shared definitions for the FIFO-fed UART transmitter: FSM state encoding,
// default data/count widths matching the byte FIFO, and line levels for the
// start and stop bits.
// -----------------------------------------------------------------------------
package fifo_uart_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 5;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    STOP
  } state_e;

endpackage : fifo_uart_pkg

// File: rtl/baud_gen.sv
// -----------------------------------------------------------------------------
// baud_gen
// Free-running bit-period counter. Counts 0..CLKS_PER_BIT-1 and flags the last
// cycle of each bit period. The transmitter pulses clear on every state entry
// so each state starts a fresh bit period.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   clear    in   restart the bit period (counter to 0 next cycle)
//   bit_tick out  high on the final cycle of a bit period
// -----------------------------------------------------------------------------
module baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clear || cnt_q == LAST) cnt_d = '0;
    else                        cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign bit_tick = (cnt_q == LAST);

endmodule : baud_gen

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Read-side consumer of the 8-bit byte FIFO. While enabled, it pops one byte
// whenever the FIFO is non-empty and sends it as an 8N1 UART frame, LSB first.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   tx_en        in   permit new frames to start
//   fifo_count   in   FIFO occupancy (sampled only while idle)
//   fifo_dout    in   FIFO read data, valid the cycle after fifo_en_out
//   fifo_en_out  out  single-cycle pop request
//   txd          out  registered serial line, idles high
//   busy         out  high whenever a frame is being fetched or sent
//   tx_done      out  pulse on the last cycle of the stop bit
// -----------------------------------------------------------------------------
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic [CNT_W-1:0]  fifo_count,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_en_out,
  output logic              txd,
  output logic              busy,
  output logic              tx_done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              txd_q, txd_d;
  logic              bit_tick;
  logic              baud_clear;

  // Restart the bit period whenever the state is about to change.
  assign baud_clear = (state_d != state_q);

  baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (baud_clear),
    .bit_tick (bit_tick)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    fifo_en_out = 1'b0;
    tx_done     = 1'b0;
    busy        = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (tx_en && fifo_count != '0) state_d = REQ;
      end
      REQ: begin
        fifo_en_out = 1'b1;
        state_d     = LOAD;
      end
      LOAD: begin
        shift_d   = fifo_dout;
        bit_idx_d = '0;
        state_d   = START;
      end
      START: begin
        if (bit_tick) state_d = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_IDX) state_d = STOP;
          else                       bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_tick) begin
          tx_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The line level is decoded from the next state and registered, so txd
    // changes exactly on state/bit boundaries and never glitches.
    unique case (state_d)
      START:   txd_d = START_BIT;
      DATA:    txd_d = shift_d[0];
      default: txd_d = STOP_BIT;
    endcase
  end

  // NOTE: the asynchronous reset forces the line high at once, abandoning any
  // frame in flight; the captured byte is deliberately dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= STOP_BIT;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
    end
  end

  assign txd = txd_q;

endmodule : fifo_uart_tx

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Drives fifo_uart_tx from a small FIFO model, decodes txd with a line monitor
// and compares decoded frames against bytes queued when they were written.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en;
  logic [4:0] fifo_count;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_en_out;
  logic       txd;
  logic       busy;
  logic       tx_done;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (8),
    .CNT_W        (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_en       (tx_en),
    .fifo_count  (fifo_count),
    .fifo_dout   (fifo_dout),
    .fifo_en_out (fifo_en_out),
    .txd         (txd),
    .busy        (busy),
    .tx_done     (tx_done)
  );

  // ---------------- FIFO model: pushes from tasks, pops on fifo_en_out ------
  logic [7:0] mem [0:63];
  int push_cnt = 0;
  int pop_cnt  = 0;

  assign fifo_count = 5'(push_cnt - pop_cnt);

  always @(posedge clk) begin
    if (fifo_en_out) begin
      fifo_dout <= mem[pop_cnt[5:0]];
      pop_cnt   <= pop_cnt + 1;
    end
  end

  // ---------------- scoreboard -----------------------------------------------
  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;
    bit         stable;
    int         done_idx;
    int         done_cnt;
  } frame_t;

  logic [7:0] exp_q[$];
  frame_t     rx_q[$];
  int         gap_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- line monitor (samples on the falling edge) --------------
  logic samp [0:FRAME-1];
  bit   mon_active  = 1'b0;
  bit   have_prev   = 1'b0;
  int   mon_idx     = 0;
  int   mon_done_idx = -1;
  int   mon_done_cnt = 0;
  int   gap_run     = 0;
  int   stray_done  = 0;

  always @(negedge clk) begin
    if (!rst) begin
      mon_active = 1'b0;
      have_prev  = 1'b0;
      gap_run    = 0;
    end else begin
      if (tx_done && !mon_active) stray_done++;
      if (!mon_active) begin
        if (txd === 1'b0) begin
          if (have_prev) gap_q.push_back(gap_run);
          mon_active   = 1'b1;
          mon_idx      = 0;
          mon_done_cnt = 0;
          mon_done_idx = -1;
        end else begin
          gap_run++;
        end
      end
      if (mon_active) begin
        samp[mon_idx] = txd;
        if (tx_done) begin
          mon_done_cnt++;
          mon_done_idx = mon_idx;
        end
        mon_idx++;
        if (mon_idx == FRAME) begin
          frame_t f;
          f.stable = 1'b1;
          for (int b = 0; b < 10; b++) begin
            f.bits[b] = samp[b*CPB];
            for (int k = 1; k < CPB; k++)
              if (samp[b*CPB+k] !== samp[b*CPB]) f.stable = 1'b0;
          end
          f.data     = f.bits[8:1];
          f.done_idx = mon_done_idx;
          f.done_cnt = mon_done_cnt;
          rx_q.push_back(f);
          mon_active = 1'b0;
          have_prev  = 1'b1;
          gap_run    = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers -----------------------------------------
  task automatic fifo_push(input logic [7:0] b, input bit expect_out);
    mem[push_cnt[5:0]] = b;
    push_cnt++;
    if (expect_out) exp_q.push_back(b);
  endtask

  task automatic wait_rx(input string name, output bit got);
    got = (rx_q.size() > 0);
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (rx_q.size() > 0) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL %s: no frame decoded within 200 cycles", name);
    end
  endtask

  task automatic expect_frame(input string name, input logic [7:0] exp_data,
                              output frame_t f);
    f = rx_q.pop_front();
    n_checks++;
    if (f.data !== exp_data) begin
      n_errors++;
      $display("FAIL %s data: got 0x%02h expected 0x%02h", name, f.data, exp_data);
    end
    n_checks++;
    if (f.bits[0] !== 1'b0 || f.bits[9] !== 1'b1) begin
      n_errors++;
      $display("FAIL %s framing: start=%b stop=%b expected start=0 stop=1",
               name, f.bits[0], f.bits[9]);
    end
    n_checks++;
    if (f.stable !== 1'b1) begin
      n_errors++;
      $display("FAIL %s bit_hold: a bit was not held for %0d cycles", name, CPB);
    end
    n_checks++;
    if (f.done_cnt !== 1 || f.done_idx !== FRAME - 1) begin
      n_errors++;
      $display("FAIL %s tx_done: count=%0d at cycle %0d expected 1 at %0d",
               name, f.done_cnt, f.done_idx + 1, FRAME);
    end
  endtask

  // ---------------- tests -----------------------------------------------------
  task automatic test_reset;
    rst   = 1'b0;
    tx_en = 1'b1;
    fifo_push(8'd78, 1'b1);
    fifo_push(8'd66, 1'b1);
    fifo_push(8'd77, 1'b1);
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({txd, fifo_en_out, busy, tx_done} !== 4'b1000) begin
        n_errors++;
        $display("FAIL reset_outputs: txd/en_out/busy/done=%b expected 1000",
                 {txd, fifo_en_out, busy, tx_done});
      end
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (fifo_en_out !== 1'b1 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL req_after_release: en_out=%b busy=%b expected 1 1",
               fifo_en_out, busy);
    end
  endtask

  task automatic test_burst;
    bit     got;
    frame_t f;
    for (int i = 0; i < 3; i++) begin
      wait_rx("burst_wait", got);
      if (got) expect_frame("burst", exp_q.pop_front(), f);
    end
    n_checks++;
    if (gap_q.size() !== 2) begin
      n_errors++;
      $display("FAIL burst_gap_count: got %0d gaps expected 2", gap_q.size());
    end
    while (gap_q.size() > 0) begin
      int g;
      g = gap_q.pop_front();
      n_checks++;
      if (g !== 3) begin
        n_errors++;
        $display("FAIL burst_gap: got %0d idle cycles expected 3", g);
      end
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || txd !== 1'b1 || pop_cnt !== 3) begin
      n_errors++;
      $display("FAIL burst_end: busy=%b txd=%b pops=%0d expected 0 1 3",
               busy, txd, pop_cnt);
    end
  endtask

  task automatic test_single;
    bit         got;
    frame_t     f;
    int         pops0;
    int         seq [10] = '{0, 1, 1, 1, 0, 1, 0, 0, 0, 1};
    logic [9:0] exp_bits;
    for (int b = 0; b < 10; b++) exp_bits[b] = seq[b][0];
    pops0 = pop_cnt;
    fifo_push(8'd23, 1'b1);
    wait_rx("single_wait", got);
    if (got) begin
      expect_frame("single", exp_q.pop_front(), f);
      n_checks++;
      if (f.bits !== exp_bits) begin
        n_errors++;
        $display("FAIL single_bits: got %b expected %b (bit0 rightmost)",
                 f.bits, exp_bits);
      end
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (pop_cnt - pops0 !== 1) begin
      n_errors++;
      $display("FAIL single_pops: got %0d pops expected 1", pop_cnt - pops0);
    end
  endtask

  task automatic test_empty;
    int pops0;
    int bad;
    pops0 = pop_cnt;
    bad   = 0;
    tx_en = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (fifo_en_out !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0 || pop_cnt !== pops0) begin
      n_errors++;
      $display("FAIL empty_idle: %0d active cycles, %0d pops, expected 0 0",
               bad, pop_cnt - pops0);
    end
  endtask

  task automatic test_gate;
    bit     got;
    bit     seen;
    frame_t f;
    int     pops0;
    pops0 = pop_cnt;
    fifo_push(8'hA5, 1'b1);
    fifo_push(8'h3C, 1'b1);
    tx_en = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mon_active) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL gate_start: start bit not seen within 20 cycles");
    end
    tx_en = 1'b0;
    wait_rx("gate_wait1", got);
    if (got) expect_frame("gate_frame1", exp_q.pop_front(), f);
    repeat (40) @(negedge clk);
    n_checks++;
    if (pop_cnt - pops0 !== 1 || busy !== 1'b0 || rx_q.size() !== 0) begin
      n_errors++;
      $display("FAIL gate_hold: pops=%0d busy=%b frames=%0d expected 1 0 0",
               pop_cnt - pops0, busy, rx_q.size());
    end
    tx_en = 1'b1;
    wait_rx("gate_wait2", got);
    if (got) expect_frame("gate_frame2", exp_q.pop_front(), f);
    n_checks++;
    if (pop_cnt - pops0 !== 2) begin
      n_errors++;
      $display("FAIL gate_pops: got %0d expected 2", pop_cnt - pops0);
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    int pops0;
    pops0 = pop_cnt;
    fifo_push(8'h5A, 1'b0);
    tx_en = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (mon_active && mon_idx >= 18) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL mid_reach: data bit 3 not reached within 100 cycles");
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || fifo_en_out !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset_now: txd=%b busy=%b en_out=%b expected 1 0 0",
               txd, busy, fifo_en_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    n_checks++;
    if (pop_cnt - pops0 !== 1 || rx_q.size() !== 0 || txd !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_after: pops=%0d frames=%0d txd=%b busy=%b expected 1 0 1 0",
               pop_cnt - pops0, rx_q.size(), txd, busy);
    end
  endtask

  initial begin
    rst   = 1'b0;
    tx_en = 1'b0;
    test_reset();
    test_burst();
    test_single();
    test_empty();
    test_gate();
    test_reset_mid();
    n_checks++;
    if (stray_done !== 0 || exp_q.size() !== 0) begin
      n_errors++;
      $display("FAIL final: stray tx_done=%0d unsent bytes=%0d expected 0 0",
               stray_done, exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_fifo_uart_tx
